// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the writeback arbiter and its per-port queues.
package wb_arbiter_pkg;

    localparam int unsigned DataWidth      = 32;
    localparam int unsigned RobDepth       = 16;
    localparam int unsigned RobW           = $clog2(RobDepth);
    localparam int unsigned ExePortsDflt   = 3;
    localparam int unsigned QueueDepthDflt = 4;
    localparam int unsigned ExpCodeW       = 4;
    localparam int unsigned RegAddrW       = 5;

    typedef logic [ExpCodeW-1:0] ExpCode_t;

    // ROB writeback destination; only addr carries the ROB id here
    typedef struct packed {
        logic [1:0]          rtype;
        logic [RegAddrW-1:0] addr;
    } RegFile_t;

    // One buffered execution result
    typedef struct packed {
        logic [RobW-1:0]      rob_id;
        logic [DataWidth-1:0] data;
        logic                 exp_;
        ExpCode_t             exp_code;
        logic                 pred_miss_;
        logic                 jump_miss_;
    } WbReq_t;

    // Idle value of a result: all active-low flags deasserted
    localparam WbReq_t WbReqIdle = '{
        rob_id:     '0,
        data:       '0,
        exp_:       1'b1,
        exp_code:   '0,
        pred_miss_: 1'b1,
        jump_miss_: 1'b1
    };

    // True when a result carries an exception or a control-flow miss
    function automatic logic has_event(input WbReq_t r);
        return (!r.exp_) || (!r.pred_miss_) || (!r.jump_miss_);
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Per-source result FIFO. A pop frees a slot in the same cycle, so push+pop
// is accepted even when full; a push into a full queue without a pop is dropped.
module wb_queue
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = QueueDepthDflt
) (
    input  logic   clk,
    input  logic   reset_,
    input  logic   flush_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  WbReq_t din_i,
    output WbReq_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    WbReq_t          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign head_o = mem_q[rd_ptr_q];

    // Status, accept decisions and next pointer/count values
    always_comb begin
        full_o   = (count_q == CntW'(DEPTH));
        empty_o  = (count_q == '0);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source queues, one grant per cycle, registered ROB
// writeback port, flush discards everything in flight.
// Optional WB_EXP_PRIO_EN: heads with an exception/miss win (lowest index)
// over round-robin.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA        = DataWidth,
    parameter int unsigned ROB_DEPTH   = RobDepth,
    parameter int unsigned EXE_PORTS   = ExePortsDflt,
    parameter int unsigned QUEUE_DEPTH = QueueDepthDflt
) (
    input  logic                                 clk,
    input  logic                                 reset_,
    input  logic                                 flush_,
    input  logic     [EXE_PORTS-1:0]             exe_e_,
    input  logic     [EXE_PORTS-1:0][$clog2(ROB_DEPTH)-1:0] exe_rob_id,
    input  logic     [EXE_PORTS-1:0][DATA-1:0]   exe_data,
    input  logic     [EXE_PORTS-1:0]             exe_exp_,
    input  ExpCode_t [EXE_PORTS-1:0]             exe_exp_code,
    input  logic     [EXE_PORTS-1:0]             exe_pred_miss_,
    input  logic     [EXE_PORTS-1:0]             exe_jump_miss_,
    output logic     [EXE_PORTS-1:0]             exe_busy,
    output logic                                 wb_e_,
    output RegFile_t                             wb_rd,
    output logic     [DATA-1:0]                  wb_data,
    output logic                                 wb_exp_,
    output ExpCode_t                             wb_exp_code,
    output logic                                 wb_pred_miss_,
    output logic                                 wb_jump_miss_
);

    localparam int unsigned ROB = $clog2(ROB_DEPTH);
    localparam int unsigned PW  = (EXE_PORTS > 1) ? $clog2(EXE_PORTS) : 1;
    localparam int unsigned PW1 = PW + 1;

    WbReq_t               head [EXE_PORTS];
    logic [EXE_PORTS-1:0] empty;
    logic [EXE_PORTS-1:0] full;
    logic [EXE_PORTS-1:0] push;
    logic [EXE_PORTS-1:0] pop;

    logic          grant_vld;
    logic [PW-1:0] win;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          wb_e_q, wb_e_d;
    WbReq_t        out_q, out_d;

    for (genvar g = 0; g < EXE_PORTS; g++) begin : g_port
        WbReq_t din;

        assign din.rob_id     = RobW'(exe_rob_id[g]);
        assign din.data       = DataWidth'(exe_data[g]);
        assign din.exp_       = exe_exp_[g];
        assign din.exp_code   = exe_exp_code[g];
        assign din.pred_miss_ = exe_pred_miss_[g];
        assign din.jump_miss_ = exe_jump_miss_[g];

        assign push[g] = ~exe_e_[g] & flush_;
        assign pop[g]  = grant_vld & flush_ & (win == PW'(g));

        wb_queue #(
            .DEPTH (QUEUE_DEPTH)
        ) u_queue (
            .clk     (clk),
            .reset_  (reset_),
            .flush_i (~flush_),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .din_i   (din),
            .head_o  (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );
    end

    assign exe_busy = full;

    // Winner selection: round-robin from rr_ptr, optionally overridden by event heads
    always_comb begin
        logic [PW1-1:0] idx;
        grant_vld = 1'b0;
        win       = '0;
        for (int unsigned k = 0; k < EXE_PORTS; k++) begin
            idx = {1'b0, rr_ptr_q} + PW1'(k);
            if (idx >= PW1'(EXE_PORTS)) idx = idx - PW1'(EXE_PORTS);
            if (!grant_vld && !empty[idx[PW-1:0]]) begin
                grant_vld = 1'b1;
                win       = idx[PW-1:0];
            end
        end
`ifdef WB_EXP_PRIO_EN
        begin
            logic found_ev;
            found_ev = 1'b0;
            for (int unsigned i = 0; i < EXE_PORTS; i++) begin
                if (!found_ev && !empty[PW'(i)] && has_event(head[PW'(i)])) begin
                    found_ev  = 1'b1;
                    grant_vld = 1'b1;
                    win       = PW'(i);
                end
            end
        end
`endif
    end

    // Next round-robin pointer and output stage contents
    always_comb begin
        logic [PW1-1:0] nxt;
        rr_ptr_d = rr_ptr_q;
        wb_e_d   = 1'b1;
        out_d    = out_q;
        nxt      = {1'b0, win} + PW1'(1);
        if (nxt >= PW1'(EXE_PORTS)) nxt = '0;
        if (!flush_) begin
            rr_ptr_d = '0;
        end else if (grant_vld) begin
            rr_ptr_d = nxt[PW-1:0];
            wb_e_d   = 1'b0;
            out_d    = head[win];
        end
    end

    // Arbiter pointer and registered writeback port
    always_ff @(posedge clk) begin
        if (!reset_) begin
            rr_ptr_q <= '0;
            wb_e_q   <= 1'b1;
            out_q    <= WbReqIdle;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wb_e_q   <= wb_e_d;
            out_q    <= out_d;
        end
    end

    assign wb_e_         = wb_e_q;
    assign wb_rd.rtype   = '0;
    assign wb_rd.addr    = RegAddrW'(out_q.rob_id);
    assign wb_data       = DATA'(out_q.data);
    assign wb_exp_       = out_q.exp_;
    assign wb_exp_code   = out_q.exp_code;
    assign wb_pred_miss_ = out_q.pred_miss_;
    assign wb_jump_miss_ = out_q.jump_miss_;

    // ROB id width is fixed by the package struct
    logic unused_rob;
    assign unused_rob = (ROB == 0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (3 ports, queue depth 4).
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset_;
    logic                 flush_;
    logic [2:0]           exe_e_;
    logic [2:0][3:0]      exe_rob_id;
    logic [2:0][31:0]     exe_data;
    logic [2:0]           exe_exp_;
    ExpCode_t [2:0]       exe_exp_code;
    logic [2:0]           exe_pred_miss_;
    logic [2:0]           exe_jump_miss_;
    logic [2:0]           exe_busy;
    logic                 wb_e_;
    RegFile_t             wb_rd;
    logic [31:0]          wb_data;
    logic                 wb_exp_;
    ExpCode_t             wb_exp_code;
    logic                 wb_pred_miss_;
    logic                 wb_jump_miss_;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    wb_arbiter dut (
        .clk            (clk),
        .reset_         (reset_),
        .flush_         (flush_),
        .exe_e_         (exe_e_),
        .exe_rob_id     (exe_rob_id),
        .exe_data       (exe_data),
        .exe_exp_       (exe_exp_),
        .exe_exp_code   (exe_exp_code),
        .exe_pred_miss_ (exe_pred_miss_),
        .exe_jump_miss_ (exe_jump_miss_),
        .exe_busy       (exe_busy),
        .wb_e_          (wb_e_),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_exp_        (wb_exp_),
        .wb_exp_code    (wb_exp_code),
        .wb_pred_miss_  (wb_pred_miss_),
        .wb_jump_miss_  (wb_jump_miss_)
    );

    always #5 clk = ~clk;

    // A source must never push into a queue that reports busy
    always @(posedge clk) begin
        if (reset_ === 1'b1 && flush_ === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                if (exe_e_[i] === 1'b0 && exe_busy[i] === 1'b1) viol++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exe_e_         = 3'b111;
        exe_rob_id     = '0;
        exe_data       = '0;
        exe_exp_       = 3'b111;
        exe_exp_code   = '0;
        exe_pred_miss_ = 3'b111;
        exe_jump_miss_ = 3'b111;
    endtask

    task automatic drive(input logic [1:0] p, input logic [3:0] id, input logic [31:0] d,
                         input logic exp_n, input ExpCode_t code);
        exe_e_[p]       = 1'b0;
        exe_rob_id[p]   = id;
        exe_data[p]     = d;
        exe_exp_[p]     = exp_n;
        exe_exp_code[p] = code;
    endtask

    task automatic do_flush();
        flush_ = 1'b0;
        tick();
        flush_ = 1'b1;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        flush_ = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset_ = 1'b1;
        checks++;
        if (wb_rd !== 7'd0) begin
            errors++; $display("FAIL reset_wb_rd: got %0h expected 0", wb_rd);
        end
        checks++;
        if ({wb_exp_, wb_pred_miss_, wb_jump_miss_} !== 3'b111) begin
            errors++; $display("FAIL reset_flags: got %b expected 111", {wb_exp_, wb_pred_miss_, wb_jump_miss_});
        end
        checks++;
        if (wb_exp_code !== 4'd0) begin
            errors++; $display("FAIL reset_exp_code: got %0h expected 0", wb_exp_code);
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (wb_e_ !== 1'b1) begin
                errors++; $display("FAIL reset_wb_e cycle %0d: got %b expected 1", c, wb_e_);
            end
            checks++;
            if (exe_busy !== 3'b000) begin
                errors++; $display("FAIL reset_busy cycle %0d: got %b expected 000", c, exe_busy);
            end
            checks++;
            if (wb_data !== 32'd0) begin
                errors++; $display("FAIL reset_wb_data cycle %0d: got %h expected 0", c, wb_data);
            end
            tick();
        end
    endtask

    task automatic test_single();
        drive(2'd1, 4'd5, 32'hDEAD_BEEF, 1'b1, 4'd0);
        tick();
        idle_inputs();
        checks++;
        if (wb_e_ !== 1'b1) begin
            errors++; $display("FAIL single_early: got wb_e_=%b expected 1", wb_e_);
        end
        tick();
        checks++;
        if (wb_e_ !== 1'b0) begin
            errors++; $display("FAIL single_wb_e: got %b expected 0", wb_e_);
        end
        checks++;
        if (wb_rd.addr !== 5'd5 || wb_rd.rtype !== 2'd0) begin
            errors++; $display("FAIL single_rd: got %0h expected addr 5", wb_rd);
        end
        checks++;
        if (wb_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_data: got %h expected deadbeef", wb_data);
        end
        checks++;
        if (wb_exp_ !== 1'b1) begin
            errors++; $display("FAIL single_exp: got %b expected 1", wb_exp_);
        end
        tick();
        checks++;
        if (wb_e_ !== 1'b1) begin
            errors++; $display("FAIL single_after: got wb_e_=%b expected 1", wb_e_);
        end
        checks++;
        if (wb_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_hold: got %h expected deadbeef", wb_data);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_ids [3];
        exp_ids[0] = 5'd1; exp_ids[1] = 5'd2; exp_ids[2] = 5'd3;
        do_flush();
        checks++;
        if (dut.rr_ptr_q !== 2'd0) begin
            errors++; $display("FAIL rr_after_flush: got %0d expected 0", dut.rr_ptr_q);
        end
        drive(2'd0, 4'd1, 32'h1000_0001, 1'b1, 4'd0);
        drive(2'd1, 4'd2, 32'h1000_0002, 1'b1, 4'd0);
        drive(2'd2, 4'd3, 32'h1000_0003, 1'b1, 4'd0);
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (wb_e_ !== 1'b0 || wb_rd.addr !== exp_ids[k]) begin
                errors++; $display("FAIL rr_order slot %0d: got wb_e_=%b id=%0d expected 0/%0d", k, wb_e_, wb_rd.addr, exp_ids[k]);
            end
        end
        tick();
        checks++;
        if (wb_e_ !== 1'b1) begin
            errors++; $display("FAIL rr_idle: got wb_e_=%b expected 1", wb_e_);
        end
        checks++;
        if (dut.rr_ptr_q !== 2'd0) begin
            errors++; $display("FAIL rr_end_ptr: got %0d expected 0", dut.rr_ptr_q);
        end
    endtask

    task automatic test_backpressure();
        int         outstanding [16];
        int         n0, n2, left;
        logic       busy_seen, drop_checked, p0_wb;
        logic [3:0] id;
        foreach (outstanding[k]) outstanding[k] = 0;
        n0 = 0; n2 = 0; busy_seen = 1'b0; drop_checked = 1'b0;
        do_flush();
        for (int cyc = 0; cyc < 60; cyc++) begin
            p0_wb = 1'b0;
            if (wb_e_ === 1'b0) begin
                id = wb_rd.addr[3:0];
                p0_wb = (id < 4'd8);
                checks++;
                if (outstanding[id] == 0) begin
                    errors++; $display("FAIL bp_dup: rob_id %0d written back with %0d outstanding, expected >0", id, outstanding[id]);
                end else begin
                    outstanding[id]--;
                end
            end
            if (busy_seen && !drop_checked) begin
                checks++;
                if (p0_wb) begin
                    drop_checked = 1'b1;
                    if (exe_busy[0] !== 1'b0) begin
                        errors++; $display("FAIL bp_busy_drop: got %b expected 0", exe_busy[0]);
                    end
                end else if (exe_busy[0] !== 1'b1) begin
                    errors++; $display("FAIL bp_busy_hold: got %b expected 1", exe_busy[0]);
                end
            end
            if (!busy_seen && exe_busy[0] === 1'b1) busy_seen = 1'b1;
            idle_inputs();
            if (!busy_seen && exe_busy[0] === 1'b0 && n0 < 8) begin
                drive(2'd0, 4'(n0), 32'hA000_0000 + 32'(n0), 1'b1, 4'd0);
                outstanding[n0]++;
                n0++;
            end
            if (exe_busy[2] === 1'b0 && n2 < 12) begin
                drive(2'd2, 4'(8 + (n2 % 8)), 32'hC000_0000 + 32'(n2), 1'b1, 4'd0);
                outstanding[8 + (n2 % 8)]++;
                n2++;
            end
            tick();
        end
        idle_inputs();
        left = 0;
        foreach (outstanding[k]) left += outstanding[k];
        checks++;
        if (left != 0) begin
            errors++; $display("FAIL bp_lost: got %0d entries never written back, expected 0", left);
        end
        checks++;
        if (busy_seen !== 1'b1) begin
            errors++; $display("FAIL bp_busy_rise: got busy_seen=%b expected 1", busy_seen);
        end
        checks++;
        if (drop_checked !== 1'b1) begin
            errors++; $display("FAIL bp_grant_after_full: got %b expected 1", drop_checked);
        end
    endtask

    task automatic test_flush();
        logic stale;
        do_flush();
        drive(2'd0, 4'd1, 32'h1000_0001, 1'b1, 4'd0);
        drive(2'd1, 4'd2, 32'h1000_0002, 1'b1, 4'd0);
        drive(2'd2, 4'd3, 32'h1000_0003, 1'b1, 4'd0);
        tick();
        drive(2'd0, 4'd4, 32'h1000_0004, 1'b1, 4'd0);
        drive(2'd1, 4'd5, 32'h1000_0005, 1'b1, 4'd0);
        drive(2'd2, 4'd6, 32'h1000_0006, 1'b1, 4'd0);
        tick();
        checks++;
        if (wb_e_ !== 1'b0 || wb_rd.addr !== 5'd1) begin
            errors++; $display("FAIL flush_pre: got wb_e_=%b id=%0d expected 0/1", wb_e_, wb_rd.addr);
        end
        idle_inputs();
        drive(2'd0, 4'd7, 32'h1000_0007, 1'b1, 4'd0);
        flush_ = 1'b0;
        tick();
        flush_ = 1'b1;
        idle_inputs();
        checks++;
        if (wb_e_ !== 1'b1) begin
            errors++; $display("FAIL flush_wb_e: got %b expected 1", wb_e_);
        end
        checks++;
        if (exe_busy !== 3'b000) begin
            errors++; $display("FAIL flush_busy: got %b expected 000", exe_busy);
        end
        checks++;
        if (dut.rr_ptr_q !== 2'd0) begin
            errors++; $display("FAIL flush_rr: got %0d expected 0", dut.rr_ptr_q);
        end
        checks++;
        if (wb_data !== 32'h1000_0001) begin
            errors++; $display("FAIL flush_data_hold: got %h expected 10000001", wb_data);
        end
        stale = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (wb_e_ !== 1'b1) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++; $display("FAIL flush_stale: got stale writeback=%b expected 0", stale);
        end
        drive(2'd2, 4'd9, 32'h1000_0009, 1'b1, 4'd0);
        tick();
        idle_inputs();
        tick();
        checks++;
        if (wb_e_ !== 1'b0 || wb_rd.addr !== 5'd9) begin
            errors++; $display("FAIL flush_resume: got wb_e_=%b id=%0d expected 0/9", wb_e_, wb_rd.addr);
        end
        tick();
        checks++;
        if (wb_e_ !== 1'b1) begin
            errors++; $display("FAIL flush_resume_idle: got %b expected 1", wb_e_);
        end
    endtask

    task automatic test_exp_prio();
        logic [4:0] exp_ids [3];
`ifdef WB_EXP_PRIO_EN
        exp_ids[0] = 5'd12; exp_ids[1] = 5'd10; exp_ids[2] = 5'd11;
`else
        exp_ids[0] = 5'd10; exp_ids[1] = 5'd11; exp_ids[2] = 5'd12;
`endif
        do_flush();
        drive(2'd0, 4'd10, 32'h2000_000A, 1'b1, 4'd0);
        drive(2'd1, 4'd11, 32'h2000_000B, 1'b1, 4'd0);
        drive(2'd2, 4'd12, 32'h2000_000C, 1'b0, 4'd3);
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (wb_e_ !== 1'b0 || wb_rd.addr !== exp_ids[k]) begin
                errors++; $display("FAIL prio_order slot %0d: got wb_e_=%b id=%0d expected 0/%0d", k, wb_e_, wb_rd.addr, exp_ids[k]);
            end
            if (wb_rd.addr == 5'd12) begin
                checks++;
                if (wb_exp_ !== 1'b0 || wb_exp_code !== 4'd3 || wb_data !== 32'h2000_000C) begin
                    errors++; $display("FAIL prio_fields: got exp_=%b code=%0d data=%h expected 0/3/2000000c", wb_exp_, wb_exp_code, wb_data);
                end
            end
        end
        tick();
        checks++;
        if (wb_e_ !== 1'b1) begin
            errors++; $display("FAIL prio_idle: got %b expected 1", wb_e_);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_exp_prio();
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL push_while_busy: got %0d violations expected 0", viol);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execution units and the reorder buffer. It collects results from EXE_PORTS execution units and buffers each in a per-port queue. It grants one result per cycle and drives the ROB's single writeback port (wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_) from a registered output stage. It discards all in-flight results when the ROB flushes.

## Interface
- DATA, `DataWidth, result width
- ROB_DEPTH, `RobDepth, reorder buffer entries
- EXE_PORTS, 3, number of execution-unit sources (≥2)
- QUEUE_DEPTH, 4, entries per source queue (power of 2, ≥2)
- ROB, $clog2(ROB_DEPTH), derived, not overridable
- Clock and reset (already decided): one clock, clk; reset is synchronous and active-low, reset_.
- clk  in  1  clock
- reset_  in  1  synchronous active-low reset
- flush_  in  1  ROB flush, active-low
- exe_e_  in  [EXE_PORTS]  result valid per source, active-low
- exe_rob_id  in  [EXE_PORTS][ROB]  destination ROB id
- exe_data  in  [EXE_PORTS][DATA]  result value
- exe_exp_  in  [EXE_PORTS]  exception flag, active-low
- exe_exp_code  in  [EXE_PORTS] ExpCode_t  exception code
- exe_pred_miss_  in  [EXE_PORTS]  branch mispredict, active-low
- exe_jump_miss_  in  [EXE_PORTS]  jump target miss, active-low
- exe_busy  out  [EXE_PORTS]  queue full; source must hold, active-high
- wb_e_  out  1  writeback valid, active-low
- wb_rd  out  RegFile_t  addr field = ROB id; other fields zero
- wb_data  out  DATA  result
- wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_  out  1/ExpCode_t/1/1  forwarded flags

## Operation
- Each port has a FIFO of QUEUE_DEPTH entries {rob_id, data, exp_, exp_code, pred_miss_, jump_miss_}, with a count of width $clog2(QUEUE_DEPTH)+1.
- Push: exe_e_[i]==0 and flush_==1. Pushing while exe_busy[i]==1 is a protocol violation; a bench assertion flags it and the RTL drops the entry.
- exe_busy[i] = (count[i]==QUEUE_DEPTH), combinational from registered count.
- Arbitration:
  - Round-robin pointer rr_ptr in [0,EXE_PORTS-1]. Search non-empty heads starting at rr_ptr, wrapping modulo EXE_PORTS.
  - The winner w pops its head; rr_ptr <= (w+1) mod EXE_PORTS.
  - No candidate: no pop; rr_ptr holds.
- Output register loads the winner's head each cycle a grant exists. Otherwise wb_e_ <= 1 and the other outputs hold their values.
- A push and a pop on the same queue in the same cycle is legal at any count, including full. Count is unchanged; busy stays high that cycle.
- Flush (flush_==0 at edge):
  - All counts and pointers clear; rr_ptr <= 0; wb_e_ <= 1.
  - Inputs presented in that cycle are discarded.
  - Flush and reset behave identically except the data outputs hold.
- Reset values: wb_e_=1, wb_exp_=1, wb_pred_miss_=1, wb_jump_miss_=1, wb_exp_code=0, wb_data=0, wb_rd=0, exe_busy=0, rr_ptr=0, all queues empty.

## Timing
- Minimum latency is 2 cycles. A result pushed at edge t reaches the queue head in cycle t+1, is granted in t+1, and wb_e_ is low during cycle t+2.
- Throughput is one writeback per cycle sustained, as long as any queue is non-empty.
- All outputs are registered. exe_busy is registered-derived, with no combinational path from exe_e_.
- flush_ takes effect at the edge on which it is sampled low. The earliest legal push after flush lands in the cycle after flush_ returns high.

## Configuration
- WB_EXP_PRIO_EN:
  - Defined: any non-empty head with exp_==0, pred_miss_==0 or jump_miss_==0 wins over round-robin, lowest index first among such heads. rr_ptr still advances to w+1.
  - Undefined: pure round-robin.

## Structure
- Shared header/package (exe.svh): WbReq_t struct {rob_id, data, exp_, exp_code, pred_miss_, jump_miss_}; the EXE_PORTS default; the QUEUE_DEPTH default constant.
- One sub-module, wb_queue:
  - Parameterised FIFO of WbReq_t with push, pop, flush, full, empty and head.
  - Instantiated EXE_PORTS times via generate.
- Arbiter and output register stay in the top module.

## Test plan
- Reset then idle: hold reset_=0 for 2 cycles. After release, wb_e_=1, exe_busy=3'b000, and wb_data=0 for 10 cycles.
- Single result: port 1 pushes rob_id=5, data=32'hDEAD_BEEF at edge t. In cycle t+2: wb_e_=0, wb_rd.addr=5, wb_data=32'hDEAD_BEEF. In t+3: wb_e_=1.
- Round-robin fairness: all 3 ports push ids 1/2/3 in the same cycle. Writebacks follow in order 1,2,3 on consecutive cycles; rr_ptr ends at 0.
- Full/backpressure with QUEUE_DEPTH=4:
  - Port 0 pushes 4 results while port 2 streams continuously (rr never idle for port 0).
  - exe_busy[0]=1 after the 4th push and drops the cycle after the first port-0 grant.
  - No entry is lost or duplicated (scoreboard by rob_id).
- Flush mid-stream: 6 entries are queued across ports and flush_=0 for one cycle. The next cycle has wb_e_=1, all exe_busy=0, and no pre-flush rob_id ever appears afterwards.
- WB_EXP_PRIO_EN defined: rr_ptr=0 with all three heads valid, and port 2's head has exp_=0. Port 2 is granted first, then ports 0 and 1. With the macro undefined, the order is 0,1,2.
